// File: rtl/mips_pkg.sv
// Shared EX-stage constants: 5-bit ALU control codes and HI/LO sequencer states.
// S_ACC exists only when HILO_ACCUM_EN is defined.
package mips_pkg;

  localparam logic [4:0] ALU_MULT  = 5'b00011;
  localparam logic [4:0] ALU_MULTU = 5'b00100;
  localparam logic [4:0] ALU_MADD  = 5'b10100;
  localparam logic [4:0] ALU_MSUB  = 5'b10101;
  localparam logic [4:0] ALU_MFHI  = 5'b10111;
  localparam logic [4:0] ALU_MFLO  = 5'b11000;
  localparam logic [4:0] ALU_MTHI  = 5'b11001;
  localparam logic [4:0] ALU_MTLO  = 5'b11010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef HILO_ACCUM_EN
    ,
    S_ACC  = 2'd2
`endif
  } seq_state_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Iterative shift-add multiplier: magnitude operands, counter, accumulator.
// The final step folds in the sign so res_o is the signed product.
module mul_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               clear_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] sum, prod;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   amag, bmag;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  assign amag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign bmag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  assign sum    = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign prod   = neg_q ? -sum : sum;
  assign last_o = cnt_q == CW'(WIDTH - 1);
  // During the last step the product is not yet registered
  assign res_o  = step_i ? prod : acc_q;

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    unique case (1'b1)
      clear_i: begin
        acc_d = '0;
        cnt_d = '0;
      end
      load_i: begin
        mcand_d = {{WIDTH{1'b0}}, amag};
        mplr_d  = bmag;
        neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        acc_d   = '0;
        cnt_d   = '0;
      end
      step_i: begin
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        acc_d   = last_o ? prod : sum;
        cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: rtl/hilo_mul_sequencer.sv
// EX-stage HI/LO owner: FSM, stall logic and HI/LO registers.
// Define HILO_ACCUM_EN to enable MADD/MSUB and the ACC state.
module hilo_mul_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic [WIDTH-1:0] Result,
  output logic             ResultValid,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  seq_state_e state_q, state_d;

  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] res;
  logic is_mult, is_multu, is_madd, is_msub;
  logic is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic is_mul, is_hilo, take, start_mul;
  logic in_mul, last, fin_mul, fin_acc;

  assign is_mult  = ALUControl == ALU_MULT;
  assign is_multu = ALUControl == ALU_MULTU;
  assign is_mthi  = ALUControl == ALU_MTHI;
  assign is_mtlo  = ALUControl == ALU_MTLO;
  assign is_mfhi  = ALUControl == ALU_MFHI;
  assign is_mflo  = ALUControl == ALU_MFLO;

`ifdef HILO_ACCUM_EN
  logic acc_op_q;
  logic sub_q;

  assign is_madd = ALUControl == ALU_MADD;
  assign is_msub = ALUControl == ALU_MSUB;
  assign fin_mul = in_mul && last && !Flush && !acc_op_q;
  assign fin_acc = (state_q == S_ACC) && !Flush;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      acc_op_q <= 1'b0;
      sub_q    <= 1'b0;
    end else if (start_mul) begin
      acc_op_q <= is_madd | is_msub;
      sub_q    <= is_msub;
    end
  end
`else
  assign is_madd = 1'b0;
  assign is_msub = 1'b0;
  assign fin_mul = in_mul && last && !Flush;
  assign fin_acc = 1'b0;
`endif

  assign is_mul  = is_mult | is_multu | is_madd | is_msub;
  assign is_hilo = is_mul | is_mthi | is_mtlo | is_mfhi | is_mflo;

  assign Busy      = state_q != S_IDLE;
  assign in_mul    = state_q == S_MUL;
  assign take      = Start && !Flush && !Busy;
  assign start_mul = take && is_mul;
  assign Stall     = Start && !Flush && Busy && is_hilo;

  assign ResultValid = take && (is_mfhi || is_mflo);
  assign Result      = !ResultValid ? '0 : (is_mfhi ? hi_q : lo_q);
  assign HI          = hi_q;
  assign LO          = lo_q;

  mul_shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (Clk),
    .rst_n   (Rst),
    .load_i  (start_mul),
    .step_i  (in_mul && !Flush),
    .clear_i (Flush),
    .signed_i(is_mult | is_madd | is_msub),
    .a_i     (A),
    .b_i     (B),
    .last_o  (last),
    .res_o   (res)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_mul) state_d = S_MUL;
`ifdef HILO_ACCUM_EN
      S_MUL:  if (last) state_d = acc_op_q ? S_ACC : S_IDLE;
      S_ACC:  state_d = S_IDLE;
`else
      S_MUL:  if (last) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    if (Flush) state_d = S_IDLE;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    unique case (1'b1)
      take && is_mthi: hi_d = A;
      take && is_mtlo: lo_d = A;
      fin_mul: {hi_d, lo_d} = res;
`ifdef HILO_ACCUM_EN
      fin_acc: {hi_d, lo_d} = sub_q ? {hi_q, lo_q} - res
                                    : {hi_q, lo_q} + res;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Scoreboard bench for hilo_mul_sequencer: a 64-bit arithmetic model
// predicts HI/LO, Busy length and MFHI/MFLO data; a monitor compares.
module tb_hilo_mul_sequencer;

  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MFHI  = 5'b10111;
  localparam logic [4:0] OP_MFLO  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } hexp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [4:0]  ALUControl = 5'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Flush = 1'b0;
  logic        Stall, Busy, ResultValid;
  logic [31:0] Result, HI, LO;

  int checks = 0;
  int errors = 0;

  hexp_t       hq[$];
  logic [31:0] rq[$];
  logic [63:0] hilo_m = 64'd0;

  hilo_mul_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .Flush(Flush), .Stall(Stall), .Busy(Busy),
    .Result(Result), .ResultValid(ResultValid), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Reference model: program-order effect of each op on {HI,LO}
  task automatic model_apply(input logic [4:0] code,
                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ps, pu;
    ps = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu = {32'd0, a} * {32'd0, b};
    case (code)
      OP_MULT: begin
        hilo_m = ps;
        hq.push_back('{hilo_m[63:32], hilo_m[31:0], 32});
      end
      OP_MULTU: begin
        hilo_m = pu;
        hq.push_back('{hilo_m[63:32], hilo_m[31:0], 32});
      end
`ifdef HILO_ACCUM_EN
      OP_MADD: begin
        hilo_m = hilo_m + ps;
        hq.push_back('{hilo_m[63:32], hilo_m[31:0], 33});
      end
      OP_MSUB: begin
        hilo_m = hilo_m - ps;
        hq.push_back('{hilo_m[63:32], hilo_m[31:0], 33});
      end
`endif
      OP_MTHI: hilo_m[63:32] = a;
      OP_MTLO: hilo_m[31:0] = a;
      OP_MFHI: rq.push_back(hilo_m[63:32]);
      OP_MFLO: rq.push_back(hilo_m[31:0]);
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic do_op(input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input bit use_model,
                       output int stalls);
    logic st;
    int   guard;
    if (use_model) model_apply(code, a, b);
    Start = 1'b1; ALUControl = code; A = a; B = b;
    stalls = 0; guard = 0;
    do begin
      @(negedge Clk);
      st = Stall;
      @(posedge Clk); #1;
      if (st) stalls++;
      guard++;
    end while (st && guard < 200);
    if (st) chk("accept_timeout", 64'(guard), 64'(0));
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((Busy || hq.size() != 0 || rq.size() != 0) && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 64'(n), 64'(0));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    int    bcnt;
    bit    prev;
    hexp_t e;
    logic [31:0] r;
    bcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        bcnt = 0;
        prev = 1'b0;
      end else begin
        if (ResultValid) begin
          if (rq.size() == 0) begin
            chk("result_unexpected", 64'(Result), 64'hX);
          end else begin
            r = rq.pop_front();
            chk("result", 64'(Result), 64'(r));
          end
        end
        if (Busy) begin
          bcnt++;
        end else if (prev) begin
          if (hq.size() == 0) begin
            chk("hilo_unexpected", {HI, LO}, 64'hX);
          end else begin
            e = hq.pop_front();
            chk("hi", 64'(HI), 64'(e.hi));
            chk("lo", 64'(LO), 64'(e.lo));
            chk("busy_cycles", 64'(bcnt), 64'(e.busy));
          end
          bcnt = 0;
        end
        prev = Busy;
      end
    end
  end

  initial begin : driver
    int st;
    logic [4:0] ops[8];
    ops = '{OP_MULT, OP_MULTU, OP_MADD, OP_MSUB,
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};

    @(negedge Clk);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_rvalid", 64'(ResultValid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, st);
    wait_idle();
    chk("mult_neg3x7", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, st);
    do_op(OP_MFLO, 32'd0, 32'd0, 1'b1, st);
    chk("mflo_stall_cycles", 64'(st), 64'd32);
    wait_idle();
    chk("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

    do_op(OP_MTHI, 32'd0, 32'd0, 1'b1, st);
    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1, st);
    do_op(OP_MADD, 32'd1, 32'd1, 1'b1, st);
    wait_idle();
`ifdef HILO_ACCUM_EN
    chk("madd_carry", {HI, LO}, 64'h0000_0001_0000_0000);
`else
    chk("madd_ignored", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif
    do_op(OP_MSUB, 32'd1, 32'd1, 1'b1, st);
    wait_idle();
    chk("msub_restore", {HI, LO}, 64'h0000_0000_FFFF_FFFF);

    // Flush at Busy cycle 10 discards the multiply
    do_op(OP_MTHI, 32'h12, 32'd0, 1'b1, st);
    do_op(OP_MTLO, 32'h34, 32'd0, 1'b1, st);
    hq.push_back('{32'h12, 32'h34, 10});
    do_op(OP_MULT, $urandom, $urandom, 1'b0, st);
    repeat (9) @(posedge Clk);
    #1 Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    wait_idle();
    chk("flush_hilo", {HI, LO}, 64'h0000_0012_0000_0034);

    // Flush on the last iteration, with a masked Start in the same cycle
    hq.push_back('{32'h12, 32'h34, 32});
    do_op(OP_MULT, 32'h1234, 32'h5678, 1'b0, st);
    repeat (31) @(posedge Clk);
    #1;
    Flush = 1'b1; Start = 1'b1; ALUControl = OP_MULTU;
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(posedge Clk); #1;
    Flush = 1'b0; Start = 1'b0;
    wait_idle();
    chk("flush_last_hilo", {HI, LO}, 64'h0000_0012_0000_0034);

    for (int i = 0; i < 60; i++) begin
      do_op(ops[$urandom_range(0, 7)], rnd_opnd(), rnd_opnd(), 1'b1, st);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(posedge Clk);
      #1;
    end
    wait_idle();
    chk("random_final_hilo", {HI, LO}, hilo_m);

    // Asynchronous reset in the middle of a MULTU with an MFLO pending
    do_op(OP_MULTU, $urandom, $urandom, 1'b0, st);
    Start = 1'b1; ALUControl = OP_MFLO;
    repeat (5) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("arst_hi", 64'(HI), 64'd0);
    chk("arst_lo", 64'(LO), 64'd0);
    chk("arst_busy", 64'(Busy), 64'd0);
    chk("arst_stall", 64'(Stall), 64'd0);
    Start = 1'b0;
    hilo_m = 64'd0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk); #1;
    do_op(OP_MFHI, 32'd0, 32'd0, 1'b1, st);
    wait_idle();

    if (hq.size() != 0) chk("hilo_left", 64'(hq.size()), 64'd0);
    if (rq.size() != 0) chk("result_left", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
